// File: rtl/mux_select_arbiter_pkg.sv
// Shared types and constants for the quad 2-to-1 selector control stage.
// Holds the arbiter state encoding plus selector select/enable levels.
package mux_select_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;
    localparam logic EN_ACTIVE = 1'b0;
    localparam logic EN_OFF    = 1'b1;

    // Grant choice out of IDLE; a tie goes to the source not served last.
    function automatic state_t pick_grant(
        input logic a_full,
        input logic b_full,
        input logic last_grant
    );
        state_t res;
        res = IDLE;
        if (a_full && b_full) begin
            res = (last_grant == SEL_B) ? GRANT_A : GRANT_B;
        end else if (a_full) begin
            res = GRANT_A;
        end else if (b_full) begin
            res = GRANT_B;
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Bundle between the two producers, the selector and the Y consumer.
// master drives the producer/consumer side, slave is the arbiter.
interface mux_select_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A_data;
    logic             A_valid;
    logic             A_ready;
    logic [WIDTH-1:0] B_data;
    logic             B_valid;
    logic             B_ready;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic             S;
    logic             E;
    logic             Y_valid;
    logic             Y_ready;

    modport master (
        output A_data, A_valid, B_data, B_valid, Y_ready,
        input  A_ready, B_ready, A_out, B_out, S, E, Y_valid
    );

    modport slave (
        input  A_data, A_valid, B_data, B_valid, Y_ready,
        output A_ready, B_ready, A_out, B_out, S, E, Y_valid
    );
endinterface

// File: rtl/mux_select_arbiter_src_hold_reg.sv
// One-entry valid/ready holding register feeding one selector input.
// The word stays frozen while full; clear empties it after a transfer.
module src_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    assign ready = !full;

    // Accept only when empty, so a refill never coincides with a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            q    <= '0;
        end else if (valid && !full) begin
            q    <= data;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin control stage driving the quad 2-to-1 selector with enable.
// S, E and Y_valid are registered from the next arbiter state.
module mux_select_arbiter #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    mux_select_arbiter_if.slave bus
);
    import mux_select_arbiter_pkg::*;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   a_full;
    logic   b_full;
    logic   a_clear;
    logic   b_clear;
    logic   sel;
    logic   en;
    logic   y_valid;

    src_hold_reg #(.WIDTH(WIDTH)) u_hold_a (
        .clk   (clk),
        .reset (reset),
        .data  (bus.A_data),
        .valid (bus.A_valid),
        .ready (bus.A_ready),
        .clear (a_clear),
        .q     (bus.A_out),
        .full  (a_full)
    );

    src_hold_reg #(.WIDTH(WIDTH)) u_hold_b (
        .clk   (clk),
        .reset (reset),
        .data  (bus.B_data),
        .valid (bus.B_valid),
        .ready (bus.B_ready),
        .clear (b_clear),
        .q     (bus.B_out),
        .full  (b_full)
    );

    assign a_clear = (state == GRANT_A) && bus.Y_ready;
    assign b_clear = (state == GRANT_B) && bus.Y_ready;

    // Flags are used as registered: a word landing this edge waits a cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                state_next = pick_grant(a_full, b_full, last_grant);
            end
            GRANT_A: begin
                if (bus.Y_ready) begin
                    state_next = b_full ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (bus.Y_ready) begin
                    state_next = a_full ? GRANT_A : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= SEL_B;
            sel        <= SEL_A;
            en         <= EN_OFF;
            y_valid    <= 1'b0;
        end else begin
            state <= state_next;
            if (a_clear) begin
                last_grant <= SEL_A;
            end else if (b_clear) begin
                last_grant <= SEL_B;
            end
            en      <= (state_next == IDLE) ? EN_OFF : EN_ACTIVE;
            y_valid <= (state_next != IDLE);
            // S keeps its last value while idle.
            unique case (state_next)
                GRANT_A: sel <= SEL_A;
                GRANT_B: sel <= SEL_B;
                default: sel <= sel;
            endcase
        end
    end

    assign bus.S       = sel;
    assign bus.E       = en;
    assign bus.Y_valid = y_valid;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed plus random bench for mux_select_arbiter.
// A per-edge source/grant model and per-source FIFOs supply expectations.
module tb_mux_select_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mux_select_arbiter_if #(.WIDTH(W)) bus ();

    mux_select_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: -1 = nothing granted, 0 = A, 1 = B
    int         cur = -1;
    int         last = 1;
    bit         full [2];
    logic [3:0] word [2];
    logic       sel = 1'b0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_xfer = 0;
    int         prev_src = -1;
    bit         fair_on = 1'b0;
    bit         acc_a;
    bit         acc_b;
    logic [3:0] y_obs = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] y_exp;
        y_exp = (cur < 0) ? 4'h0 : word[cur];
        chk("A_ready", bus.A_ready, !full[0]);
        chk("B_ready", bus.B_ready, !full[1]);
        chk("A_out", bus.A_out, word[0]);
        chk("B_out", bus.B_out, word[1]);
        chk("E", bus.E, (cur < 0));
        chk("Y_valid", bus.Y_valid, (cur >= 0));
        chk("S", bus.S, sel);
        chk("inv_valid_en", bus.Y_valid, !bus.E);
        chk("inv_granted_full",
            bus.Y_valid && (bus.S ? bus.B_ready : bus.A_ready), 0);
        y_obs = bus.E ? 4'h0 : (bus.S ? bus.B_out : bus.A_out);
        chk("Y", y_obs, y_exp);
    endtask

    task automatic tick();
        bit         fa;
        bit         fb;
        bit         xfer;
        int         nc;
        logic [3:0] e;
        @(posedge clk);
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (reset) begin
            full[0] = 0;
            full[1] = 0;
            word[0] = '0;
            word[1] = '0;
            cur = -1;
            last = 1;
            sel = 1'b0;
            qa.delete();
            qb.delete();
            prev_src = -1;
        end else begin
            fa = full[0];
            fb = full[1];
            xfer = (cur >= 0) && bus.Y_ready;
            if (cur < 0) begin
                if (fa && fb) nc = 1 - last;
                else if (fa) nc = 0;
                else if (fb) nc = 1;
                else nc = -1;
            end else if (xfer) begin
                nc = full[1 - cur] ? 1 - cur : -1;
            end else begin
                nc = cur;
            end
            if (xfer) begin
                e = (cur == 0) ? qa.pop_front() : qb.pop_front();
                chk("y_order", y_obs, e);
                if (fair_on && prev_src >= 0) begin
                    chk("alternate", cur, 1 - prev_src);
                end
                prev_src = cur;
                full[cur] = 0;
                last = cur;
                n_xfer++;
            end
            if (bus.A_valid && !fa) begin
                word[0] = bus.A_data;
                full[0] = 1;
                qa.push_back(bus.A_data);
                acc_a = 1'b1;
            end
            if (bus.B_valid && !fb) begin
                word[1] = bus.B_data;
                full[1] = 1;
                qb.push_back(bus.B_data);
                acc_b = 1'b1;
            end
            if (nc >= 0) sel = nc[0];
            cur = nc;
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit av, input logic [3:0] ad, input bit bv,
                         input logic [3:0] bd, input bit yr);
        bus.A_valid = av;
        bus.A_data  = ad;
        bus.B_valid = bv;
        bus.B_data  = bd;
        bus.Y_ready = yr;
    endtask

    initial begin
        int start;
        int k;
        drive(0, 4'h0, 0, 4'h0, 1);

        // Reset for two cycles
        reset = 1'b1;
        tick();
        tick();
        chk("rst_E", bus.E, 1);
        chk("rst_Y_valid", bus.Y_valid, 0);
        chk("rst_A_ready", bus.A_ready, 1);
        chk("rst_B_ready", bus.B_ready, 1);
        chk("rst_A_out", bus.A_out, 0);
        reset = 1'b0;
        tick();

        // Single A word
        drive(1, 4'hA, 0, 4'h0, 1);
        tick();
        drive(0, 4'h0, 0, 4'h0, 1);
        chk("single_A_ready", bus.A_ready, 0);
        chk("single_E_still_off", bus.E, 1);
        tick();
        chk("single_S", bus.S, 0);
        chk("single_E", bus.E, 0);
        chk("single_A_out", bus.A_out, 4'hA);
        tick();
        chk("single_idle_E", bus.E, 1);
        tick();

        // Tie: A wins first, then B with no bubble
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 4'h3, 1, 4'hC, 1);
        tick();
        drive(0, 4'h0, 0, 4'h0, 1);
        tick();
        chk("tie_first_S", bus.S, 0);
        chk("tie_first_Y", y_obs, 4'h3);
        tick();
        chk("tie_second_S", bus.S, 1);
        chk("tie_second_E", bus.E, 0);
        chk("tie_second_Y", y_obs, 4'hC);
        tick();
        chk("tie_idle_E", bus.E, 1);

        // Backpressure on a B grant
        drive(0, 4'h0, 1, 4'h6, 0);
        tick();
        drive(0, 4'h0, 0, 4'h0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_S", bus.S, 1);
            chk("bp_E", bus.E, 0);
            chk("bp_B_out", bus.B_out, 4'h6);
            chk("bp_B_ready", bus.B_ready, 0);
        end
        bus.Y_ready = 1'b1;
        start = n_xfer;
        tick();
        chk("bp_released", n_xfer - start, 1);
        chk("bp_idle_E", bus.E, 1);

        // Reset in the middle of a B grant
        drive(0, 4'h0, 1, 4'h9, 0);
        tick();
        drive(0, 4'h0, 0, 4'h0, 0);
        tick();
        chk("pre_rst_S", bus.S, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_E", bus.E, 1);
        chk("rst_mid_B_ready", bus.B_ready, 1);
        tick();

        // Fairness: both sources refill every opportunity
        fair_on = 1'b1;
        prev_src = -1;
        drive(1, 4'($urandom), 1, 4'($urandom), 1);
        start = n_xfer;
        for (int i = 0; i < 200 && n_xfer < start + 20; i++) begin
            tick();
            chk("one_outstanding", (qa.size() <= 1) && (qb.size() <= 1), 1);
            if (acc_a) bus.A_data = 4'($urandom);
            if (acc_b) bus.B_data = 4'($urandom);
        end
        chk("fair_count", n_xfer - start, 20);
        fair_on = 1'b0;
        drive(0, 4'h0, 0, 4'h0, 1);
        tick();
        tick();
        tick();

        // Source A streaming alone
        k = 1;
        drive(1, 4'h1, 0, 4'h0, 1);
        start = n_xfer;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (acc_a) begin
                k++;
                bus.A_data = 4'(k);
                if (k > 3) bus.A_valid = 1'b0;
            end
        end
        chk("stream_count", n_xfer - start, 3);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
